// File: rtl/vector100_pkg.sv
// vector100 link: shared word geometry for the bit-serial receiver.
// Optional build macro VECTOR100_DESER_REV_EN is consumed by the top.
package vector100_pkg;

  localparam int WIDTH = 100;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

endpackage

// File: rtl/vector100_shreg.sv
// vector100 link: shift register filled one bit per enabled cycle.
// Synchronous clear wins over shift.
module vector100_shreg
  import vector100_pkg::*;
#(
  parameter int N = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         din,
  output logic [N-1:0] q
);

  // shift new bits in at the LSB end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[N-2:0], din};
    end
  end

endmodule

// File: rtl/vector100_deser.sv
// vector100 link: serial-to-parallel receiver, double-buffered output.
// Define VECTOR100_DESER_REV_EN to place bit k received at m_data[k].
module vector100_deser #(
  parameter int WIDTH = vector100_pkg::WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_bit,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             frame_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] word_map;
  logic             at_last;
  logic             acc;
  logic             done;
  logic             early;
  logic             sh_unused;

  assign at_last   = (cnt == LAST);
  assign s_ready   = !(at_last && m_valid && !m_ready);
  assign acc       = s_valid && s_ready;
  assign done      = acc && at_last;
  assign early     = acc && s_last && !at_last;
  assign word      = {sh[WIDTH-2:0], s_bit};
  assign sh_unused = sh[WIDTH-1];

  vector100_shreg #(
    .N(WIDTH)
  ) u_shreg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (acc),
    .clr  (early || done),
    .din  (s_bit),
    .q    (sh)
  );

`ifdef VECTOR100_DESER_REV_EN
  // first received bit goes to bit 0
  always_comb begin
    word_map = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word_map[i] = word[WIDTH-1-i];
    end
  end
`else
  assign word_map = word;
`endif

  // bit counter, output buffer and framing flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= acc && (s_last != at_last);
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (acc) begin
        if (at_last) begin
          cnt     <= '0;
          m_data  <= word_map;
          m_valid <= 1'b1;
        end else if (s_last) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector100_deser.sv
// vector100 link: bench for the serial receiver.
// Reference keeps received bits in a queue and builds words from it.
module tb_vector100_deser;

  localparam int W = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_bit = 1'b0;
  logic         s_last = 1'b0;
  logic         m_ready = 1'b0;
  logic         s_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         frame_err;

  int total = 0;
  int bad = 0;

  bit           q[$];
  logic         ev = 1'b0;
  logic [W-1:0] ed = '0;
  logic         ef = 1'b0;
  bit           acc_now;

  vector100_deser dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_bit    (s_bit),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] build();
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
`ifdef VECTOR100_DESER_REV_EN
      w[k] = q[k];
`else
      w[W-1-k] = q[k];
`endif
    end
    return w;
  endfunction

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0b exp=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk1("m_valid", m_valid, ev);
    chkw("m_data", m_data, ed);
    chk1("frame_err", frame_err, ef);
  endtask

  // one clock: drive at negedge, check ready, update model, check outputs
  task automatic cyc(input bit v, input bit b, input bit l,
                     input bit mr);
    bit rdy;
    bit tr;
    bit done;
    s_valid = v;
    s_bit   = b;
    s_last  = l;
    m_ready = mr;
    #1;
    rdy = !(q.size() == W - 1 && ev && !mr);
    chk1("s_ready", s_ready, rdy);
    acc_now = v && rdy;
    @(posedge clk);
    tr   = ev && mr;
    done = 1'b0;
    ef   = 1'b0;
    if (acc_now) begin
      if (q.size() == W - 1) begin
        q.push_back(b);
        ed   = build();
        done = 1'b1;
        ef   = !l;
        q.delete();
      end else if (l) begin
        ef = 1'b1;
        q.delete();
      end else begin
        q.push_back(b);
      end
    end
    if (done) ev = 1'b1;
    else if (tr) ev = 1'b0;
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    @(posedge clk);
    q.delete();
    ev = 1'b0;
    ed = '0;
    ef = 1'b0;
    @(negedge clk);
    check_outs();
    chk1("rst_s_ready", s_ready, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input int n, input int last_pos,
                           input bit mr);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'($urandom), i == last_pos, mr);
    end
  endtask

  initial begin
    logic [103:0] t;
    logic [W-1:0] pat;
    int c;
    int sent;
    int first_done;
    bit mr;

    // reset state
    do_reset();
    do_reset();

    // A5 pattern, MSB-first stream
    t = {13{8'hA5}};
`ifdef VECTOR100_DESER_REV_EN
    for (int k = 0; k < W; k++) pat[k] = t[103-k];
`else
    pat = t[103:4];
`endif
    for (int i = 0; i < W; i++) begin
      cyc(1'b1, t[103-i], i == W - 1, 1'b1);
    end
    chkw("a5_word", m_data, pat);
    chk1("a5_valid", m_valid, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk1("a5_valid_drop", m_valid, 1'b0);

    // two words, downstream stalled 150 cycles after first
    c = 0;
    sent = 0;
    first_done = -1;
    while ((sent < 2 * W || ev) && c < 800) begin
      mr = (first_done >= 0) && (c - first_done >= 150);
      cyc(sent < 2 * W, 1'($urandom), (sent % W) == W - 1, mr);
      if (acc_now) sent++;
      if (first_done < 0 && sent == W) first_done = c;
      c++;
    end
    total++;
    assert (c < 800) else begin
      bad++;
      $error("FAIL stall_timeout obs=%0d exp=<800", c);
    end

    // completion and transfer in the same cycle
    send_word(W, W - 1, 1'b0);
    send_word(W - 1, -1, 1'b0);
    cyc(1'b1, 1'($urandom), 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("same_cycle_valid", m_valid, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // early last at bit 40, then a clean word
    send_word(41, 40, 1'b1);
    chk1("early_err", frame_err, 1'b1);
    send_word(W, W - 1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // last never asserted
    send_word(W, -1, 1'b1);
    chk1("miss_err", frame_err, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // reset mid-word with a held output
    send_word(W, W - 1, 1'b0);
    send_word(60, -1, 1'b0);
    do_reset();
    send_word(W, W - 1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bit l;
      if (q.size() == W - 1) l = ($urandom % 8) != 0;
      else l = ($urandom % 60) == 0;
      cyc(($urandom % 4) != 0, 1'($urandom), l,
          ($urandom % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
